// File: rtl/obstacle_pool_if.sv
// Spawn handshake, scroll controls and packed car state between generator, pool and renderer.
// Pure wiring; the master drives controls and spawn requests, the slave returns registered car state.
interface obstacle_pool_if #(
  parameter int NUM_OBS = 4,
  parameter int X_W     = 8,
  parameter int Y_W     = 10,
  parameter int SPEED_W = 3,
  parameter int CNT_W   = 16
);
  localparam int SLOT_W = (NUM_OBS > 1) ? $clog2(NUM_OBS) : 1;
  localparam int ACT_W  = $clog2(NUM_OBS + 1);

  logic                     clear;
  logic                     freeze;
  logic                     upsig;
  logic [SPEED_W-1:0]       speed;
  logic                     spawn_req;
  logic [X_W-1:0]           spawn_x;
  logic                     spawn_ready;
  logic [SLOT_W-1:0]        spawn_slot;
  logic [NUM_OBS-1:0]       on;
  logic [NUM_OBS*X_W-1:0]   car_x;
  logic [NUM_OBS*Y_W-1:0]   car_y;
  logic [ACT_W-1:0]         active_count;
  logic                     pass_pulse;
  logic [CNT_W-1:0]         pass_count;

  modport master (
    output clear, freeze, upsig, speed, spawn_req, spawn_x,
    input  spawn_ready, spawn_slot, on, car_x, car_y, active_count, pass_pulse, pass_count
  );

  modport slave (
    input  clear, freeze, upsig, speed, spawn_req, spawn_x,
    output spawn_ready, spawn_slot, on, car_x, car_y, active_count, pass_pulse, pass_count
  );
endinterface

// File: rtl/obstacle_pool.sv
// Pool of NUM_OBS obstacle cars scrolled together on each upsig rising edge; state updates one cycle after inputs.
// Spawns are accepted only while spawn_ready is high; requests seen without it are dropped, never queued.
module obstacle_pool #(
  parameter int NUM_OBS      = 4,
  parameter int X_W          = 8,
  parameter int Y_W          = 10,
  parameter int TRACK_HEIGHT = 480,
  parameter int X_MAX        = 255,
  parameter int SPEED_W      = 3,
  parameter int CNT_W        = 16
) (
  input  logic           clk,
  input  logic           init_n,
  obstacle_pool_if.slave bus
);
  localparam int SLOT_W = (NUM_OBS > 1) ? $clog2(NUM_OBS) : 1;
  localparam int ACT_W  = $clog2(NUM_OBS + 1);

  logic [NUM_OBS-1:0]          on_q, on_d;
  logic [NUM_OBS-1:0][X_W-1:0] x_q, x_d;
  logic [NUM_OBS-1:0][Y_W-1:0] y_q, y_d;
  logic [CNT_W-1:0]            pass_count_q, pass_count_d;
  logic                        pass_pulse_q, pass_pulse_d;
  logic                        upsig_q, upsig_d;

  logic                        step;
  logic                        spawn_ready;
  logic                        spawn_go;
  logic [SLOT_W-1:0]           spawn_slot;
  logic [X_W-1:0]              spawn_x_clamped;
  logic [ACT_W-1:0]            active_count;
  logic [NUM_OBS-1:0]          passed;
  logic [CNT_W-1:0]            pass_inc;
  logic [Y_W:0]                sum;

  // A tick edge arriving while frozen is consumed by upsig_q and lost.
  assign step        = bus.upsig & ~upsig_q & ~bus.freeze;
  assign spawn_ready = ~(&on_q) & ~bus.freeze;
  assign spawn_go    = bus.spawn_req & spawn_ready;

  assign spawn_x_clamped = ({1'b0, bus.spawn_x} > (X_W+1)'(X_MAX)) ? X_W'(X_MAX) : bus.spawn_x;

  always_comb begin
    spawn_slot = '0;
    for (int i = NUM_OBS - 1; i >= 0; i--) begin
      if (!on_q[i]) spawn_slot = SLOT_W'(i);
    end
  end

  always_comb begin
    active_count = '0;
    for (int i = 0; i < NUM_OBS; i++) begin
      active_count = active_count + ACT_W'(on_q[i]);
    end
  end

  always_comb begin
    upsig_d  = bus.upsig;
    on_d     = on_q;
    x_d      = x_q;
    y_d      = y_q;
    passed   = '0;
    pass_inc = '0;
    sum      = '0;
    if (bus.clear) begin
      on_d = '0;
      y_d  = '0;
    end else begin
      for (int i = 0; i < NUM_OBS; i++) begin
        if (step && on_q[i]) begin
          sum = {1'b0, y_q[i]} + (Y_W+1)'(bus.speed);
          if (sum >= (Y_W+1)'(TRACK_HEIGHT)) begin
            on_d[i]   = 1'b0;
            y_d[i]    = '0;
            passed[i] = 1'b1;
          end else begin
            y_d[i] = sum[Y_W-1:0];
          end
        end
        // The spawn target was inactive this cycle, so the step above never touched it.
        if (spawn_go && (spawn_slot == SLOT_W'(i))) begin
          on_d[i] = 1'b1;
          y_d[i]  = '0;
          x_d[i]  = spawn_x_clamped;
        end
        pass_inc = pass_inc + CNT_W'(passed[i]);
      end
    end
    pass_pulse_d = |passed;
    pass_count_d = pass_count_q + pass_inc;
  end

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      on_q         <= '0;
      x_q          <= '0;
      y_q          <= '0;
      pass_count_q <= '0;
      pass_pulse_q <= 1'b0;
      upsig_q      <= 1'b0;
    end else begin
      on_q         <= on_d;
      x_q          <= x_d;
      y_q          <= y_d;
      pass_count_q <= pass_count_d;
      pass_pulse_q <= pass_pulse_d;
      upsig_q      <= upsig_d;
    end
  end

  assign bus.spawn_ready  = spawn_ready;
  assign bus.spawn_slot   = spawn_slot;
  assign bus.on           = on_q;
  assign bus.car_x        = x_q;
  assign bus.car_y        = y_q;
  assign bus.active_count = active_count;
  assign bus.pass_pulse   = pass_pulse_q;
  assign bus.pass_count   = pass_count_q;
endmodule

// File: tb/tb_obstacle_pool.sv
// Bench for obstacle_pool: directed vector table, hand-written pass/clear sequences,
// then random traffic compared every cycle against a slot-array model of the road.
module tb_obstacle_pool;
  localparam int NOBS  = 4;
  localparam int XW    = 8;
  localparam int YW    = 10;
  localparam int SPW   = 3;
  localparam int CW    = 16;
  localparam int TRACK = 480;
  localparam int XMAX  = 255;

  logic clk;
  logic init_n;

  obstacle_pool_if #(.NUM_OBS(NOBS), .X_W(XW), .Y_W(YW), .SPEED_W(SPW), .CNT_W(CW)) bus ();

  obstacle_pool #(
    .NUM_OBS(NOBS), .X_W(XW), .Y_W(YW), .TRACK_HEIGHT(TRACK),
    .X_MAX(XMAX), .SPEED_W(SPW), .CNT_W(CW)
  ) dut (
    .clk    (clk),
    .init_n (init_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: one entry per road slot.
  int m_on [NOBS];
  int m_x  [NOBS];
  int m_y  [NOBS];
  int m_pc;
  int m_pp;
  int m_prev;

  typedef struct {
    int clr; int frz; int up; int spd; int req; int sx;
    int e_on; int e_y0; int e_x0; int e_act; int e_pc; int e_pp; int e_slot; int e_rdy;
  } vec_t;

  vec_t vecs [15];

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int cx(int i);
    return int'(bus.car_x[i*XW +: XW]);
  endfunction

  function automatic int cy(int i);
    return int'(bus.car_y[i*YW +: YW]);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NOBS; i++) begin
      m_on[i] = 0; m_x[i] = 0; m_y[i] = 0;
    end
    m_pc = 0; m_pp = 0; m_prev = 0;
  endfunction

  function automatic void model_clock();
    int free_idx = -1;
    int npass = 0;
    int stp;
    for (int i = NOBS - 1; i >= 0; i--) if (m_on[i] == 0) free_idx = i;
    stp = (bus.upsig && (m_prev == 0) && !bus.freeze) ? 1 : 0;
    m_prev = int'(bus.upsig);
    if (bus.clear) begin
      for (int i = 0; i < NOBS; i++) begin
        m_on[i] = 0; m_y[i] = 0;
      end
      m_pp = 0;
    end else begin
      if (stp == 1) begin
        for (int i = 0; i < NOBS; i++) begin
          if (m_on[i] == 1) begin
            if (m_y[i] + int'(bus.speed) >= TRACK) begin
              m_on[i] = 0; m_y[i] = 0; npass++;
            end else begin
              m_y[i] = m_y[i] + int'(bus.speed);
            end
          end
        end
      end
      if (bus.spawn_req && (free_idx >= 0) && !bus.freeze) begin
        m_on[free_idx] = 1;
        m_y[free_idx]  = 0;
        m_x[free_idx]  = (int'(bus.spawn_x) > XMAX) ? XMAX : int'(bus.spawn_x);
      end
      m_pp = (npass > 0) ? 1 : 0;
      m_pc = (m_pc + npass) % (1 << CW);
    end
  endfunction

  task automatic cmp_model();
    int act = 0;
    int low = -1;
    for (int i = 0; i < NOBS; i++) begin
      chk($sformatf("model on[%0d]", i), int'(bus.on[i]), m_on[i]);
      chk($sformatf("model x[%0d]", i), cx(i), m_x[i]);
      chk($sformatf("model y[%0d]", i), cy(i), m_y[i]);
      act += m_on[i];
    end
    for (int i = NOBS - 1; i >= 0; i--) if (m_on[i] == 0) low = i;
    chk("model active_count", int'(bus.active_count), act);
    chk("model pass_count", int'(bus.pass_count), m_pc);
    chk("model pass_pulse", int'(bus.pass_pulse), m_pp);
    chk("model spawn_ready", int'(bus.spawn_ready), ((act < NOBS) && !bus.freeze) ? 1 : 0);
    if (low >= 0) chk("model spawn_slot", int'(bus.spawn_slot), low);
  endtask

  task automatic drive(int c, int f, int u, int s, int r, int x);
    bus.clear     = c[0];
    bus.freeze    = f[0];
    bus.upsig     = u[0];
    bus.speed     = SPW'(s);
    bus.spawn_req = r[0];
    bus.spawn_x   = XW'(x);
  endtask

  task automatic tick();
    model_clock();
    @(posedge clk);
    #1;
    cmp_model();
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0);
  endtask

  task automatic spawn(int x);
    drive(0, 0, 0, 0, 1, x);
    tick();
    idle();
  endtask

  task automatic do_clear();
    drive(1, 0, 0, 0, 0, 0);
    tick();
    idle();
  endtask

  task automatic step_n(int n, int spd);
    for (int k = 0; k < n; k++) begin
      drive(0, 0, 1, spd, 0, 0);
      tick();
      drive(0, 0, 0, spd, 0, 0);
      tick();
    end
  endtask

  initial begin
    //           clr frz up spd req sx   on  y0 x0  act pc pp slot rdy
    vecs[0]  = '{0, 0, 0, 0, 1, 40,  1, 0, 40, 1, 0, 0, 1, 1};
    vecs[1]  = '{0, 0, 1, 3, 0, 0,   1, 3, 40, 1, 0, 0, 1, 1};
    vecs[2]  = '{0, 0, 1, 3, 0, 0,   1, 3, 40, 1, 0, 0, 1, 1};
    vecs[3]  = '{0, 0, 1, 3, 0, 0,   1, 3, 40, 1, 0, 0, 1, 1};
    vecs[4]  = '{0, 0, 0, 3, 0, 0,   1, 3, 40, 1, 0, 0, 1, 1};
    vecs[5]  = '{0, 0, 1, 3, 0, 0,   1, 6, 40, 1, 0, 0, 1, 1};
    vecs[6]  = '{0, 0, 0, 3, 0, 0,   1, 6, 40, 1, 0, 0, 1, 1};
    vecs[7]  = '{0, 1, 1, 3, 1, 99,  1, 6, 40, 1, 0, 0, 1, 0};
    vecs[8]  = '{0, 0, 1, 3, 0, 0,   1, 6, 40, 1, 0, 0, 1, 1};
    vecs[9]  = '{0, 0, 0, 3, 0, 0,   1, 6, 40, 1, 0, 0, 1, 1};
    vecs[10] = '{0, 0, 1, 3, 0, 0,   1, 9, 40, 1, 0, 0, 1, 1};
    vecs[11] = '{0, 0, 0, 0, 0, 0,   1, 9, 40, 1, 0, 0, 1, 1};
    vecs[12] = '{0, 0, 1, 0, 0, 0,   1, 9, 40, 1, 0, 0, 1, 1};
    vecs[13] = '{0, 0, 0, 0, 1, 200, 3, 9, 40, 2, 0, 0, 2, 1};
    vecs[14] = '{1, 0, 1, 3, 1, 77,  0, 0, 40, 0, 0, 0, 0, 1};

    init_n = 1'b0;
    idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset on", int'(bus.on), 0);
    chk("reset car_y", int'(bus.car_y), 0);
    chk("reset car_x", int'(bus.car_x), 0);
    chk("reset pass_count", int'(bus.pass_count), 0);
    chk("reset pass_pulse", int'(bus.pass_pulse), 0);
    chk("reset spawn_slot", int'(bus.spawn_slot), 0);
    chk("reset spawn_ready", int'(bus.spawn_ready), 1);
    init_n = 1'b1;

    // Directed vector table
    foreach (vecs[v]) begin
      drive(vecs[v].clr, vecs[v].frz, vecs[v].up, vecs[v].spd, vecs[v].req, vecs[v].sx);
      tick();
      chk($sformatf("vec%0d on", v), int'(bus.on), vecs[v].e_on);
      chk($sformatf("vec%0d y0", v), cy(0), vecs[v].e_y0);
      chk($sformatf("vec%0d x0", v), cx(0), vecs[v].e_x0);
      chk($sformatf("vec%0d active", v), int'(bus.active_count), vecs[v].e_act);
      chk($sformatf("vec%0d pass_count", v), int'(bus.pass_count), vecs[v].e_pc);
      chk($sformatf("vec%0d pass_pulse", v), int'(bus.pass_pulse), vecs[v].e_pp);
      chk($sformatf("vec%0d spawn_slot", v), int'(bus.spawn_slot), vecs[v].e_slot);
      chk($sformatf("vec%0d spawn_ready", v), int'(bus.spawn_ready), vecs[v].e_rdy);
    end
    idle();

    // Ten ticks at speed 3, then a held upsig counts once
    spawn(40);
    step_n(10, 3);
    chk("ten ticks y0", cy(0), 30);
    drive(0, 0, 1, 3, 0, 0);
    repeat (5) tick();
    chk("held upsig y0", cy(0), 33);
    idle();
    tick();
    do_clear();

    // Fill every slot, then a request must be ignored
    for (int i = 0; i < NOBS; i++) spawn(i + 1);
    chk("full spawn_ready", int'(bus.spawn_ready), 0);
    chk("full active", int'(bus.active_count), NOBS);
    drive(0, 0, 0, 0, 1, 77);
    tick();
    idle();
    chk("full ignore on", int'(bus.on), 15);
    for (int i = 0; i < NOBS; i++) chk($sformatf("full ignore x%0d", i), cx(i), i + 1);
    do_clear();

    // Arrange slots 0 and 2 at y=478 with slot 1 trailing, then pass both together
    spawn(11);
    step_n(30, 7);
    chk("arr y0 210", cy(0), 210);
    spawn(22);
    step_n(39, 7);
    chk("arr slot0 passed on", int'(bus.on), 2);
    chk("arr y1 273", cy(1), 273);
    chk("arr pc 1", int'(bus.pass_count), 1);
    spawn(33);
    spawn(44);
    step_n(30, 7);
    chk("arr slot1 passed on", int'(bus.on), 5);
    chk("arr y2 210", cy(2), 210);
    chk("arr pc 2", int'(bus.pass_count), 2);
    spawn(55);
    step_n(38, 7);
    step_n(1, 2);
    chk("arr y0 478", cy(0), 478);
    chk("arr y2 478", cy(2), 478);
    chk("arr y1 268", cy(1), 268);
    drive(0, 0, 1, 2, 0, 0);
    tick();
    chk("dual pass on", int'(bus.on), 2);
    chk("dual pass y0", cy(0), 0);
    chk("dual pass y2", cy(2), 0);
    chk("dual pass y1", cy(1), 270);
    chk("dual pass x0 held", cx(0), 33);
    chk("dual pass x2 held", cx(2), 44);
    chk("dual pass pulse", int'(bus.pass_pulse), 1);
    chk("dual pass count", int'(bus.pass_count), 4);
    chk("dual pass spawn_slot", int'(bus.spawn_slot), 0);
    idle();
    tick();
    chk("dual pass pulse drop", int'(bus.pass_pulse), 0);
    do_clear();

    // Step and spawn together; then clear beats a step that would pass cars
    spawn(5);
    spawn(6);
    step_n(25, 4);
    chk("sim y1 100", cy(1), 100);
    drive(0, 0, 1, 4, 1, 9);
    tick();
    chk("sim y1 104", cy(1), 104);
    chk("sim new y2", cy(2), 0);
    chk("sim new x2", cx(2), 9);
    chk("sim on", int'(bus.on), 7);
    drive(0, 0, 0, 7, 0, 0);
    tick();
    step_n(53, 7);
    chk("pre clear y0", cy(0), 475);
    drive(1, 0, 1, 7, 0, 0);
    tick();
    chk("clear on", int'(bus.on), 0);
    chk("clear car_y", int'(bus.car_y), 0);
    chk("clear pass_count", int'(bus.pass_count), 4);
    chk("clear pass_pulse", int'(bus.pass_pulse), 0);
    idle();
    tick();

    // Random traffic against the model
    for (int c = 0; c < 4000; c++) begin
      drive(($urandom_range(0, 511) == 0) ? 1 : 0,
            ($urandom_range(0, 7) == 0) ? 1 : 0,
            int'($urandom_range(0, 1)),
            int'($urandom_range(0, 7)),
            ($urandom_range(0, 2) == 0) ? 1 : 0,
            int'($urandom_range(0, 255)));
      tick();
    end

    // Asynchronous reset in the middle of a step and a spawn
    drive(0, 0, 1, 5, 1, 10);
    #2;
    init_n = 1'b0;
    #1;
    model_reset();
    chk("midreset on", int'(bus.on), 0);
    chk("midreset car_y", int'(bus.car_y), 0);
    chk("midreset car_x", int'(bus.car_x), 0);
    chk("midreset pass_count", int'(bus.pass_count), 0);
    chk("midreset pass_pulse", int'(bus.pass_pulse), 0);
    @(posedge clk);
    #1;
    cmp_model();
    idle();
    init_n = 1'b1;
    tick();
    spawn(250);
    chk("post reset spawn on", int'(bus.on), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
